// File: rtl/bounce_emulator.sv
// Mechanical switch emulator: turns a clean level request into a bouncy edge
// train with LFSR-randomised segment widths, then holds the final level settled.
module bounce_emulator #(
    parameter int          CNT_W      = 16,
    parameter int          WR_W       = 3,
    parameter int          MIN_W      = 2,
    parameter int          SETTLE_CYC = 1000,
    parameter logic [15:0] LFSR_SEED  = 16'hACE1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       level_req,
    input  logic [3:0] bounces_cfg,
    output logic       sw_out,
    output logic       busy,
    output logic       done
);
    localparam logic [15:0]      LFSR_TAPS = 16'hB400;
    localparam logic [CNT_W-1:0] MIN_M1    = CNT_W'(MIN_W - 1);
    localparam logic [CNT_W-1:0] SETTLE_M1 = CNT_W'(SETTLE_CYC - 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        HOLD   = 2'd1,
        SETTLE = 2'd2
    } state_t;

    state_t           state_reg, state_next;
    logic [15:0]      lfsr_reg, lfsr_next;
    logic [4:0]       edges_left_reg, edges_left_next;
    logic [CNT_W-1:0] timer_reg, timer_next;
    logic             sw_reg, sw_next;
    logic             busy_reg, busy_next;
    logic             done_reg, done_next;

    logic [CNT_W-1:0] seg_load;
    logic             timer_expired;

    // Galois step: the bit shifted out of position 0 is folded into the taps.
    generate
        for (genvar gi = 0; gi < 16; gi++) begin : g_lfsr
            if (gi == 15) begin : g_top
                assign lfsr_next[gi] = LFSR_TAPS[gi] & lfsr_reg[0];
            end else begin : g_mid
                assign lfsr_next[gi] = lfsr_reg[gi+1] ^ (LFSR_TAPS[gi] & lfsr_reg[0]);
            end
        end
    endgenerate

    // The timer holds "cycles remaining minus one", so a load of W-1 expires
    // exactly W cycles after the edge that loaded it.
    assign seg_load      = MIN_M1 + CNT_W'(lfsr_reg[WR_W-1:0]);
    assign timer_expired = (timer_reg == '0);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg      <= IDLE;
            lfsr_reg       <= LFSR_SEED;
            edges_left_reg <= '0;
            timer_reg      <= '0;
            sw_reg         <= 1'b0;
            busy_reg       <= 1'b0;
            done_reg       <= 1'b0;
        end else begin
            state_reg      <= state_next;
            lfsr_reg       <= lfsr_next;
            edges_left_reg <= edges_left_next;
            timer_reg      <= timer_next;
            sw_reg         <= sw_next;
            busy_reg       <= busy_next;
            done_reg       <= done_next;
        end
    end

    always_comb begin
        state_next      = state_reg;
        edges_left_next = edges_left_reg;
        timer_next      = timer_reg;
        sw_next         = sw_reg;
        busy_next       = busy_reg;
        done_next       = 1'b0;

        case (state_reg)
            IDLE: begin
                busy_next = 1'b0;
                if (level_req != sw_reg) begin
                    sw_next         = ~sw_reg;
                    edges_left_next = {bounces_cfg, 1'b0};
                    timer_next      = seg_load;
                    busy_next       = 1'b1;
                    state_next      = HOLD;
                end
            end
            HOLD: begin
                if (!timer_expired) begin
                    timer_next = timer_reg - 1'b1;
                end else if (edges_left_reg != '0) begin
                    sw_next         = ~sw_reg;
                    edges_left_next = edges_left_reg - 1'b1;
                    timer_next      = seg_load;
                end else begin
                    timer_next = SETTLE_M1;
                    state_next = SETTLE;
                end
            end
            SETTLE: begin
                if (!timer_expired) begin
                    timer_next = timer_reg - 1'b1;
                end else begin
                    done_next  = 1'b1;
                    busy_next  = 1'b0;
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
                busy_next  = 1'b0;
            end
        endcase
    end

    assign sw_out = sw_reg;
    assign busy   = busy_reg;
    assign done   = done_reg;

endmodule

// File: tb/tb_bounce_emulator.sv
// Bench for bounce_emulator: an LFSR model predicts every edge and done pulse
// into queues; a monitor pops and compares them as the DUT produces them.
module tb_bounce_emulator;
    localparam int MIN_W   = 2;
    localparam int WR_W    = 3;
    localparam int SETTLE  = 20;
    localparam int DEB_WIN = 16;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       level_req = 1'b0;
    logic [3:0] bounces_cfg = 4'd0;
    logic       sw_out, busy, done;

    int compared = 0;
    int mismatched = 0;

    always #5 clk = ~clk;

    bounce_emulator #(
        .CNT_W(16), .WR_W(WR_W), .MIN_W(MIN_W), .SETTLE_CYC(SETTLE), .LFSR_SEED(16'hACE1)
    ) dut (
        .clk(clk), .rst(rst), .level_req(level_req), .bounces_cfg(bounces_cfg),
        .sw_out(sw_out), .busy(busy), .done(done)
    );

    function automatic logic [15:0] step(input logic [15:0] v);
        return {1'b0, v[15:1]} ^ (v[0] ? 16'hB400 : 16'h0000);
    endfunction

    function automatic logic [15:0] adv(input logic [15:0] v, input int n);
        logic [15:0] r = v;
        for (int i = 0; i < n; i++) r = step(r);
        return r;
    endfunction

    int          cyc = 0;
    logic [15:0] m_lfsr;
    always @(posedge clk) cyc <= cyc + 1;
    always @(posedge clk or negedge rst)
        if (!rst) m_lfsr <= 16'hACE1;
        else      m_lfsr <= step(m_lfsr);

    // Reference debouncer for the loopback check.
    logic deb_state;
    int   deb_cnt;
    int   presses = 0;
    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            deb_state <= 1'b0;
            deb_cnt   <= 0;
        end else if (sw_out != deb_state) begin
            if (deb_cnt == DEB_WIN - 1) begin
                deb_state <= sw_out;
                deb_cnt   <= 0;
                if (sw_out) presses <= presses + 1;
            end else begin
                deb_cnt <= deb_cnt + 1;
            end
        end else begin
            deb_cnt <= 0;
        end
    end

    typedef struct {
        int   cyc;
        logic lvl;
    } edge_t;
    edge_t edge_q[$];
    int    done_q[$];
    int    edges_seen = 0;
    int    done_seen  = 0;

    // Sequence starting at posedge s with LFSR value l (pre-edge s).
    task automatic predict(input int s, input logic [15:0] l, input int b, input logic target,
                           output int done_cyc, output logic [15:0] l_end, output int w0);
        int          t  = s;
        logic [15:0] v  = l;
        logic        lv = target;
        int          w;
        edge_t       e;
        w0 = MIN_W + int'(l[WR_W-1:0]);
        for (int i = 0; i < 2 * b + 1; i++) begin
            e.cyc = t;
            e.lvl = lv;
            edge_q.push_back(e);
            w  = MIN_W + int'(v[WR_W-1:0]);
            v  = adv(v, w);
            t += w;
            lv = ~lv;
        end
        done_cyc = t + SETTLE;
        done_q.push_back(done_cyc);
        l_end = v;
    endtask

    task automatic monitor();
        logic  prev_sw = 1'b0;
        logic  prev_done = 1'b0;
        logic  in_seq = 1'b0;
        int    last_edge = 0;
        int    exp_done;
        edge_t e;
        forever begin
            @(negedge clk);
            if (!rst) begin
                prev_sw   = 1'b0;
                prev_done = 1'b0;
                in_seq    = 1'b0;
            end else begin
                if (sw_out !== prev_sw) begin
                    edges_seen++;
                    compared++;
                    if (edge_q.size() == 0) begin
                        mismatched++;
                        $display("FAIL edge_unexpected: cycle %0d level %b, no edge expected", cyc, sw_out);
                    end else begin
                        e = edge_q.pop_front();
                        if (cyc !== e.cyc || sw_out !== e.lvl) begin
                            mismatched++;
                            $display("FAIL edge: got cycle %0d level %b, expected cycle %0d level %b",
                                     cyc, sw_out, e.cyc, e.lvl);
                        end
                    end
                    if (in_seq) begin
                        compared++;
                        if (cyc - last_edge < MIN_W || cyc - last_edge > MIN_W + 7) begin
                            mismatched++;
                            $display("FAIL segment_width: got %0d, expected 2..9", cyc - last_edge);
                        end
                    end
                    in_seq    = 1'b1;
                    last_edge = cyc;
                    prev_sw   = sw_out;
                end
                if (done === 1'b1) begin
                    done_seen++;
                    in_seq = 1'b0;
                    compared++;
                    if (done_q.size() == 0) begin
                        mismatched++;
                        $display("FAIL done_unexpected: pulse at cycle %0d, none expected", cyc);
                    end else begin
                        exp_done = done_q.pop_front();
                        if (cyc !== exp_done) begin
                            mismatched++;
                            $display("FAIL done_time: got cycle %0d, expected cycle %0d", cyc, exp_done);
                        end
                    end
                    compared++;
                    if (busy !== 1'b0 || prev_done !== 1'b0) begin
                        mismatched++;
                        $display("FAIL done_cycle: got busy=%b prev_done=%b, expected 0/0", busy, prev_done);
                    end
                end
                prev_done = done;
            end
        end
    endtask

    task automatic start_seq(input logic target, input int b, output int done_cyc,
                             output logic [15:0] l_end, output int w0);
        @(negedge clk);
        predict(cyc + 1, m_lfsr, b, target, done_cyc, l_end, w0);
        level_req   = target;
        bounces_cfg = 4'(b);
    endtask

    task automatic wait_idle(input int budget, input string name);
        int n = 0;
        while (edge_q.size() != 0 || done_q.size() != 0 || busy !== 1'b0) begin
            @(negedge clk);
            n++;
            if (n > budget) begin
                compared++;
                mismatched++;
                $display("FAIL %s_timeout: still busy after %0d cycles, expected idle", name, budget);
                edge_q.delete();
                done_q.delete();
                break;
            end
        end
    endtask

    task automatic check_seq(input string name, input int e0, input int d0, input int exp_edges,
                             input logic exp_lvl);
        compared++;
        if (edges_seen - e0 !== exp_edges || done_seen - d0 !== 1 + (exp_edges > 11 ? 1 : 0)
            || sw_out !== exp_lvl) begin
            mismatched++;
            $display("FAIL %s: got edges=%0d dones=%0d level=%b, expected edges=%0d level=%b",
                     name, edges_seen - e0, done_seen - d0, sw_out, exp_edges, exp_lvl);
        end
    endtask

    task automatic test_reset();
        int d, w;
        logic [15:0] l;
        #1 rst = 1'b0;
        level_req = 1'b1;
        repeat (3) begin
            @(negedge clk);
            compared++;
            if ({sw_out, busy, done} !== 3'b000) begin
                mismatched++;
                $display("FAIL reset_hold: got sw/busy/done=%b, expected 000", {sw_out, busy, done});
            end
        end
        @(negedge clk);
        predict(cyc + 1, m_lfsr, 0, 1'b1, d, l, w);
        rst = 1'b1;
        @(negedge clk);
        compared++;
        if (sw_out !== 1'b1 || busy !== 1'b1) begin
            mismatched++;
            $display("FAIL reset_release: got sw=%b busy=%b, expected 1/1", sw_out, busy);
        end
        wait_idle(200, "reset");
    endtask

    task automatic test_clean_edge();
        int d, w, e0, d0, n, busy_cnt;
        logic [15:0] l;
        start_seq(1'b0, 0, d, l, w);
        wait_idle(200, "clean_pre");
        e0 = edges_seen;
        d0 = done_seen;
        start_seq(1'b1, 0, d, l, w);
        busy_cnt = 0;
        n = 0;
        while (n < 200) begin
            @(negedge clk);
            n++;
            if (busy === 1'b1) busy_cnt++;
            else break;
        end
        compared++;
        if (busy_cnt !== w + SETTLE || busy_cnt < 22 || busy_cnt > 29) begin
            mismatched++;
            $display("FAIL clean_busy_len: got %0d cycles, expected %0d", busy_cnt, w + SETTLE);
        end
        wait_idle(200, "clean");
        check_seq("clean_edge", e0, d0, 1, 1'b1);
    endtask

    task automatic test_bounce_count();
        int d, w, e0, d0;
        logic [15:0] l;
        start_seq(1'b0, 0, d, l, w);
        wait_idle(200, "bounce_pre");
        e0 = edges_seen; d0 = done_seen;
        start_seq(1'b1, 3, d, l, w);
        wait_idle(300, "bounce_rise");
        check_seq("bounce_rise", e0, d0, 7, 1'b1);
        e0 = edges_seen; d0 = done_seen;
        start_seq(1'b0, 3, d, l, w);
        wait_idle(300, "bounce_fall");
        check_seq("bounce_fall", e0, d0, 7, 1'b0);
    endtask

    task automatic test_request_during_busy();
        int d1, d2, w, e0, d0;
        logic [15:0] l1, l2;
        e0 = edges_seen; d0 = done_seen;
        start_seq(1'b1, 5, d1, l1, w);
        repeat (10) @(negedge clk);
        level_req   = 1'b0;
        bounces_cfg = 4'd2;
        predict(d1 + 1, adv(l1, SETTLE + 1), 2, 1'b0, d2, l2, w);
        wait_idle(1000, "busy_req");
        check_seq("request_during_busy", e0, d0, 16, 1'b0);
    endtask

    task automatic test_reset_mid_sequence();
        int d, w, e0, d0;
        logic [15:0] l;
        start_seq(1'b1, 4, d, l, w);
        repeat (8) @(negedge clk);
        compared++;
        if (busy !== 1'b1) begin
            mismatched++;
            $display("FAIL mid_busy: got busy=%b, expected 1", busy);
        end
        #2 rst = 1'b0;
        #1;
        compared++;
        if ({sw_out, busy, done} !== 3'b000) begin
            mismatched++;
            $display("FAIL mid_reset: got sw/busy/done=%b, expected 000", {sw_out, busy, done});
        end
        edge_q.delete();
        done_q.delete();
        repeat (3) @(negedge clk);
        e0 = edges_seen; d0 = done_seen;
        predict(cyc + 1, m_lfsr, 4, 1'b1, d, l, w);
        rst = 1'b1;
        wait_idle(400, "mid_rerun");
        check_seq("reset_mid_rerun", e0, d0, 9, 1'b1);
    endtask

    task automatic test_loopback();
        int d, w, p0;
        logic [15:0] l;
        p0 = presses;
        for (int i = 0; i < 3; i++) begin
            start_seq(1'b0, 4, d, l, w);
            wait_idle(400, "loop_fall");
            start_seq(1'b1, 4, d, l, w);
            wait_idle(400, "loop_rise");
        end
        compared++;
        if (presses - p0 !== 3) begin
            mismatched++;
            $display("FAIL loopback_presses: got %0d, expected 3", presses - p0);
        end
    endtask

    initial begin
        fork
            monitor();
        join_none
        test_reset();
        test_clean_edge();
        test_bounce_count();
        test_request_during_busy();
        test_reset_mid_sequence();
        test_loopback();
        repeat (5) @(negedge clk);
        compared++;
        if (edge_q.size() != 0 || done_q.size() != 0) begin
            mismatched++;
            $display("FAIL leftover: got %0d edges %0d dones pending, expected 0", edge_q.size(), done_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
